// File: rtl/uart_fifo_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_fifo_ctrl_if
// Description : Host-side byte interface of uart_fifo_ctrl. Carries the TX
//               write handshake and the RX read handshake.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_fifo_ctrl_if;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       rd_ready;

  // Host / CPU side
  modport master (
    output wr_valid, wr_data, rd_ready,
    input  wr_ready, rd_valid, rd_data
  );

  // FIFO controller side
  modport slave (
    input  wr_valid, wr_data, rd_ready,
    output wr_ready, rd_valid, rd_data
  );
endinterface
`default_nettype wire

// File: rtl/uart_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_fifo_ctrl
// Description : Sequencer between the host byte interface and the serial UART
//               core. TX FIFO with frame-at-a-time launch, RX FIFO capture
//               with overrun mirror, break and sticky error status.
//               Optional macro UART_FIFO_CTRL_RTS_EN adds rts_n / cts_n flow
//               control.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_fifo_ctrl #(
  parameter int TX_DEPTH   = 16,
  parameter int RX_DEPTH   = 16,
  parameter int RTS_MARGIN = 4
) (
  input  wire                       clk,
  input  wire                       reset,
  uart_fifo_ctrl_if.slave           host,
  input  wire                       brk_req,
  input  wire                       clr_status,
  output logic [$clog2(TX_DEPTH):0] tx_level,
  output logic [$clog2(RX_DEPTH):0] rx_level,
  output logic                      rx_ovf,
  output logic                      frame_err,
  output logic                      tx_busy,
  output logic                      u_tdata,
  output logic [15:0]               u_wdata,
  input  wire  [15:0]               u_rdata,
  input  wire                       u_txint,
  input  wire                       u_rxint,
  output logic                      u_rbfmirror,
`ifdef UART_FIFO_CTRL_RTS_EN
  output logic                      rts_n,
  input  wire                       cts_n,
`endif
  output logic                      u_uartbrk
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int TX_LW = TX_AW + 1;
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int RX_LW = RX_AW + 1;
  localparam logic [TX_LW-1:0] C_TX_FULL = TX_LW'(TX_DEPTH);
  localparam logic [RX_LW-1:0] C_RX_FULL = RX_LW'(RX_DEPTH);

  localparam logic [1:0] T_IDLE  = 2'd0;
  localparam logic [1:0] T_START = 2'd1;
  localparam logic [1:0] T_RUN   = 2'd2;

  // TX FIFO storage and control
  logic [7:0]       tx_mem_q [TX_DEPTH];
  logic [TX_AW-1:0] tx_wr_q, tx_rd_q;
  logic [TX_LW-1:0] tx_level_q, tx_level_d;
  logic             w_tx_push, w_tx_pop;

  // RX FIFO storage and control
  logic [7:0]       rx_mem_q [RX_DEPTH];
  logic [RX_AW-1:0] rx_wr_q, rx_rd_q;
  logic [RX_LW-1:0] rx_level_q, rx_level_d;
  logic             w_rx_full, w_rx_push, w_rx_pop;

  // TX sequencer
  logic [1:0]       state_q, state_d;
  logic [2:0]       wd_q, wd_d;
  logic             w_can_launch, w_launch;
  logic             w_tbe, w_cts_ok;

  // Output and status registers
  logic             u_tdata_q;
  logic [15:0]      u_wdata_q;
  logic             rbfmirror_q, uartbrk_q;
  logic             rx_ovf_q, rx_ovf_d, frame_err_q, frame_err_d;

  // Status bits of u_rdata that this block does not consume
  logic             w_unused_rdata;
  assign w_unused_rdata = ^{u_rdata[15:14], u_rdata[12:10], u_rdata[8]};

  assign w_tbe = u_rdata[13];

`ifdef UART_FIFO_CTRL_RTS_EN
  logic             rts_n_q;
  logic [RX_LW-1:0] w_rx_free;
  assign w_rx_free = C_RX_FULL - rx_level_q;
  assign w_cts_ok  = ~cts_n;
  assign rts_n     = rts_n_q;

  // rts_n with hysteresis on the number of free RX entries
  always_ff @(posedge clk) begin
    if (reset) begin
      rts_n_q <= 1'b0;
    end else if (w_rx_free <= RX_LW'(RTS_MARGIN)) begin
      rts_n_q <= 1'b1;
    end else if (w_rx_free >= RX_LW'(2 * RTS_MARGIN)) begin
      rts_n_q <= 1'b0;
    end
  end
`else
  assign w_cts_ok = 1'b1;
`endif

  // ---------------------------------------------------------------- TX FIFO
  assign host.wr_ready = (tx_level_q != C_TX_FULL);
  assign w_tx_push     = host.wr_valid & host.wr_ready;
  assign w_tx_pop      = w_launch;
  assign tx_level_d    = tx_level_q + TX_LW'(w_tx_push) - TX_LW'(w_tx_pop);

  // TX FIFO storage write; contents need no reset since the level gates reads
  always_ff @(posedge clk) begin
    if (w_tx_push) tx_mem_q[tx_wr_q] <= host.wr_data;
  end

  // TX FIFO pointers and occupancy; pointers wrap naturally (power-of-two depth)
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wr_q    <= '0;
      tx_rd_q    <= '0;
      tx_level_q <= '0;
    end else begin
      if (w_tx_push) tx_wr_q <= tx_wr_q + 1'b1;
      if (w_tx_pop)  tx_rd_q <= tx_rd_q + 1'b1;
      tx_level_q <= tx_level_d;
    end
  end

  // ---------------------------------------------------------- TX sequencer
  assign w_can_launch = (tx_level_q != '0) & w_tbe & ~brk_req & w_cts_ok;

  // Sequencer state register with start watchdog counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= T_IDLE;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
    end
  end

  // Next state: launch, wait for the start pulse (or watchdog), wait for TBE
  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    case (state_q)
      T_IDLE: begin
        if (w_can_launch) begin
          state_d = T_START;
          wd_d    = '0;
        end
      end
      T_START: begin
        if (u_txint || (wd_q == 3'd7)) state_d = T_RUN;
        else                           wd_d    = wd_q + 3'd1;
      end
      T_RUN: begin
        if (w_tbe) state_d = T_IDLE;
      end
      default: state_d = T_IDLE;
    endcase
  end

  // Sequencer outputs: a launch pops the FIFO and strobes the UART once
  always_comb begin
    w_launch = 1'b0;
    if (state_q == T_IDLE) w_launch = w_can_launch;
  end

  // Registered UART load strobe and data word (8 data bits + stop bit)
  always_ff @(posedge clk) begin
    if (reset) begin
      u_tdata_q <= 1'b0;
      u_wdata_q <= 16'h0000;
    end else begin
      u_tdata_q <= w_launch;
      if (w_launch) u_wdata_q <= {7'b0, 1'b1, tx_mem_q[tx_rd_q]};
    end
  end

  // ---------------------------------------------------------------- RX FIFO
  assign w_rx_full     = (rx_level_q == C_RX_FULL);
  assign w_rx_push     = u_rxint & ~w_rx_full;
  assign host.rd_valid = (rx_level_q != '0);
  assign host.rd_data  = rx_mem_q[rx_rd_q];
  assign w_rx_pop      = host.rd_valid & host.rd_ready;
  assign rx_level_d    = rx_level_q + RX_LW'(w_rx_push) - RX_LW'(w_rx_pop);

  // RX FIFO storage write
  always_ff @(posedge clk) begin
    if (w_rx_push) rx_mem_q[rx_wr_q] <= u_rdata[7:0];
  end

  // RX FIFO pointers, occupancy and full mirror aligned with rx_level
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_wr_q     <= '0;
      rx_rd_q     <= '0;
      rx_level_q  <= '0;
      rbfmirror_q <= 1'b0;
    end else begin
      if (w_rx_push) rx_wr_q <= rx_wr_q + 1'b1;
      if (w_rx_pop)  rx_rd_q <= rx_rd_q + 1'b1;
      rx_level_q  <= rx_level_d;
      rbfmirror_q <= (rx_level_d == C_RX_FULL);
    end
  end

  // Sticky flags: a set event outranks a same-cycle clear
  always_comb begin
    rx_ovf_d    = (rx_ovf_q & ~clr_status) | (u_rxint & w_rx_full);
    frame_err_d = (frame_err_q & ~clr_status) | (w_rx_push & ~u_rdata[9]);
  end

  // Status and break registers
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_ovf_q    <= 1'b0;
      frame_err_q <= 1'b0;
      uartbrk_q   <= 1'b0;
    end else begin
      rx_ovf_q    <= rx_ovf_d;
      frame_err_q <= frame_err_d;
      uartbrk_q   <= brk_req;
    end
  end

  assign tx_level    = tx_level_q;
  assign rx_level    = rx_level_q;
  assign rx_ovf      = rx_ovf_q;
  assign frame_err   = frame_err_q;
  assign tx_busy     = (tx_level_q != '0) | (state_q != T_IDLE);
  assign u_tdata     = u_tdata_q;
  assign u_wdata     = u_wdata_q;
  assign u_rbfmirror = rbfmirror_q;
  assign u_uartbrk   = uartbrk_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_fifo_ctrl
// Description : Directed self-checking bench for uart_fifo_ctrl with a small
//               behavioural UART model and TX/RX scoreboards.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_fifo_ctrl;
  localparam int FRAME = 40;

  logic        clk = 1'b0;
  logic        reset, brk_req, clr_status;
  logic [4:0]  tx_level, rx_level;
  logic        rx_ovf, frame_err, tx_busy, u_tdata, u_rbfmirror, u_uartbrk;
  logic [15:0] u_wdata, u_rdata;
  logic        u_txint, u_rxint;
`ifdef UART_FIFO_CTRL_RTS_EN
  logic        rts_n;
`endif

  // UART model state
  logic        tbe, tbe_block, tbe_eff;
  int          tcnt;
  logic [7:0]  rx_byte;
  logic        rx_stop;

  int total = 0;
  int bad   = 0;
  int n_strobe = 0;
  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  int rx_cnt = 0;

  uart_fifo_ctrl_if hif ();

  uart_fifo_ctrl #(.TX_DEPTH(16), .RX_DEPTH(16), .RTS_MARGIN(4)) dut (
    .clk(clk), .reset(reset), .host(hif), .brk_req(brk_req),
    .clr_status(clr_status), .tx_level(tx_level), .rx_level(rx_level),
    .rx_ovf(rx_ovf), .frame_err(frame_err), .tx_busy(tx_busy),
    .u_tdata(u_tdata), .u_wdata(u_wdata), .u_rdata(u_rdata),
    .u_txint(u_txint), .u_rxint(u_rxint), .u_rbfmirror(u_rbfmirror),
`ifdef UART_FIFO_CTRL_RTS_EN
    .rts_n(rts_n), .cts_n(1'b0),
`endif
    .u_uartbrk(u_uartbrk)
  );

  always #5 clk = ~clk;

  assign tbe_eff = tbe & ~tbe_block;
  assign u_rdata = {2'b00, tbe_eff, 3'b000, rx_stop, 1'b0, rx_byte};

  // UART model: a load drops TBE, pulses txint next cycle, TBE returns after FRAME
  always @(posedge clk) begin
    if (reset) begin
      tbe <= 1'b1; tcnt <= 0; u_txint <= 1'b0;
    end else begin
      u_txint <= u_tdata;
      if (u_tdata) begin
        tbe <= 1'b0; tcnt <= FRAME;
      end else if (tcnt > 1) begin
        tcnt <= tcnt - 1;
      end else if (tcnt == 1) begin
        tcnt <= 0; tbe <= 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // TX monitor: every strobe must see TBE high and carry the next queued byte
  always @(negedge clk) begin
    if (!reset && u_tdata === 1'b1) begin
      n_strobe++;
      chk("tbe_at_launch", {31'b0, tbe_eff}, 1);
      chk("tx_queue_nonempty", {31'b0, txq.size() != 0}, 1);
      if (txq.size() != 0) chk("tx_data", {16'b0, u_wdata}, {16'b0, 8'h01, txq.pop_front()});
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (tx_busy !== 1'b0 && n < limit) begin tick(); n++; end
    chk("tx_idle", {31'b0, tx_busy}, 0);
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop, input logic clr);
    rx_byte = b; rx_stop = stop; u_rxint = 1'b1; clr_status = clr;
    if (rx_cnt < 16) begin rxq.push_back(b); rx_cnt++; end
    tick();
    u_rxint = 1'b0; clr_status = 1'b0; rx_stop = 1'b1;
    tick();
  endtask

  task automatic rx_pop();
    chk("rd_valid", {31'b0, hif.rd_valid}, 1);
    if (rxq.size() != 0) chk("rd_data", {24'b0, hif.rd_data}, {24'b0, rxq.pop_front()});
    hif.rd_ready = 1'b1;
    tick();
    hif.rd_ready = 1'b0;
    rx_cnt--;
  endtask

  initial begin
    int s0;
    reset = 1'b1; brk_req = 1'b0; clr_status = 1'b0; tbe_block = 1'b0;
    u_rxint = 1'b0; rx_byte = 8'h00; rx_stop = 1'b1;
    hif.wr_valid = 1'b0; hif.wr_data = 8'h00; hif.rd_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    // Reset state
    chk("rst_wr_ready",  {31'b0, hif.wr_ready}, 1);
    chk("rst_rd_valid",  {31'b0, hif.rd_valid}, 0);
    chk("rst_u_tdata",   {31'b0, u_tdata}, 0);
    chk("rst_u_wdata",   {16'b0, u_wdata}, 0);
    chk("rst_rbfmirror", {31'b0, u_rbfmirror}, 0);
    chk("rst_uartbrk",   {31'b0, u_uartbrk}, 0);
    chk("rst_levels",    {22'b0, tx_level, rx_level}, 0);
    chk("rst_flags",     {29'b0, rx_ovf, frame_err, tx_busy}, 0);

    // Single byte: strobe two cycles after the push
    hif.wr_valid = 1'b1; hif.wr_data = 8'h5A; txq.push_back(8'h5A);
    tick();
    hif.wr_valid = 1'b0;
    chk("lat_c1_tdata", {31'b0, u_tdata}, 0);
    chk("lat_c1_level", {27'b0, tx_level}, 1);
    tick();
    chk("lat_c2_tdata", {31'b0, u_tdata}, 1);
    chk("lat_c2_wdata", {16'b0, u_wdata}, 32'h015A);
    wait_idle(FRAME + 20);

    // Burst of 17 into a stalled UART: 16 accepted, 17th dropped
    tbe_block = 1'b1;
    for (int i = 0; i < 16; i++) begin
      hif.wr_valid = 1'b1; hif.wr_data = 8'(i); txq.push_back(8'(i));
      tick();
    end
    chk("full_wr_ready", {31'b0, hif.wr_ready}, 0);
    chk("full_level", {27'b0, tx_level}, 16);
    hif.wr_data = 8'h10;
    tick();
    hif.wr_valid = 1'b0;
    chk("drop_level", {27'b0, tx_level}, 16);
    s0 = n_strobe;
    tbe_block = 1'b0;
    wait_idle(16 * (FRAME + 20));
    chk("burst_strobes", n_strobe - s0, 16);
    chk("burst_all_sent", txq.size(), 0);
    chk("burst_level", {27'b0, tx_level}, 0);

    // RX: 20 frames with no reads, overrun after 16
    for (int i = 0; i < 20; i++) rx_frame(8'h30 + 8'(i), 1'b1, 1'b0);
    chk("rx_sat_level", {27'b0, rx_level}, 16);
    chk("rx_rbfmirror", {31'b0, u_rbfmirror}, 1);
    chk("rx_ovf_set", {31'b0, rx_ovf}, 1);
    chk("rx_no_ferr", {31'b0, frame_err}, 0);
    for (int i = 0; i < 16; i++) rx_pop();
    chk("rx_empty_level", {27'b0, rx_level}, 0);
    chk("rx_empty_valid", {31'b0, hif.rd_valid}, 0);
    chk("rx_rbf_clear", {31'b0, u_rbfmirror}, 0);
    clr_status = 1'b1; tick(); clr_status = 1'b0;
    chk("ovf_cleared", {31'b0, rx_ovf}, 0);

    // Framing error, then clear racing a new error
    rx_frame(8'hA3, 1'b0, 1'b0);
    chk("ferr_set", {31'b0, frame_err}, 1);
    rx_pop();
    rx_frame(8'h11, 1'b0, 1'b1);
    chk("ferr_set_wins", {31'b0, frame_err}, 1);
    rx_pop();
    clr_status = 1'b1; tick(); clr_status = 1'b0;
    chk("ferr_cleared", {31'b0, frame_err}, 0);

    // Break during a frame holds the queue
    s0 = n_strobe;
    for (int i = 0; i < 3; i++) begin
      hif.wr_valid = 1'b1; hif.wr_data = 8'hB0 + 8'(i); txq.push_back(8'hB0 + 8'(i));
      tick();
    end
    hif.wr_valid = 1'b0;
    for (int n = 0; n < 20 && n_strobe == s0; n++) tick();
    brk_req = 1'b1;
    tick(); tick();
    chk("brk_uartbrk", {31'b0, u_uartbrk}, 1);
    repeat (3 * FRAME) tick();
    chk("brk_one_frame", n_strobe - s0, 1);
    chk("brk_held_level", {27'b0, tx_level}, 2);
    brk_req = 1'b0;
    wait_idle(3 * (FRAME + 20));
    chk("brk_resume_sent", txq.size(), 0);
    chk("brk_released", {31'b0, u_uartbrk}, 0);

    // Reset while running with 5 bytes queued
    for (int i = 0; i < 6; i++) begin
      hif.wr_valid = 1'b1; hif.wr_data = 8'hC0 + 8'(i); txq.push_back(8'hC0 + 8'(i));
      tick();
    end
    hif.wr_valid = 1'b0;
    tick(); tick();
    chk("pre_rst_level", {27'b0, tx_level}, 5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    txq.delete();
    chk("mid_rst_level", {27'b0, tx_level}, 0);
    chk("mid_rst_busy", {31'b0, tx_busy}, 0);
    chk("mid_rst_tdata", {31'b0, u_tdata}, 0);
    chk("mid_rst_wdata", {16'b0, u_wdata}, 0);
    chk("mid_rst_wr_ready", {31'b0, hif.wr_ready}, 1);
    s0 = n_strobe;
    repeat (3 * FRAME) tick();
    chk("post_rst_quiet", n_strobe - s0, 0);
    hif.wr_valid = 1'b1; hif.wr_data = 8'h77; txq.push_back(8'h77);
    tick();
    hif.wr_valid = 1'b0;
    wait_idle(FRAME + 20);
    chk("post_rst_sent", txq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/uart_fifo_ctrl.md
Name: uart_fifo_ctrl

Overview:
Sequencer between the host/CPU byte interface and the serial UART core in the SNES/MiSTer serial path (MIDI 31250 baud or 115200 baud).
- Buffers outgoing bytes in a TX FIFO and launches them into the UART one frame at a time, using the UART's TBE status and txint pulse.
- Captures every received frame on rxint into an RX FIFO and drives the UART's rbfmirror, which yields a correct overrun flag.
- Owns break generation and the sticky error status.

Parameters:
TX_DEPTH, 16, TX FIFO entries; power of two, 2..256.
RX_DEPTH, 16, RX FIFO entries; power of two, 2..256.
RTS_MARGIN, 4, free RX entries at which rts_n deasserts (used only with the optional feature).

Ports:
clk  in  1  system clock (21.477 MHz domain)
reset  in  1  synchronous, active-high reset
wr_valid  in  1  host offers a TX byte
wr_data  in  8  TX byte
wr_ready  out  1  TX FIFO not full
rd_valid  out  1  RX FIFO not empty
rd_data  out  8  head of RX FIFO; valid while rd_valid
rd_ready  in  1  host pops the RX head
brk_req  in  1  level; hold serial line in break
clr_status  in  1  pulse; clears rx_ovf and frame_err
tx_level  out  $clog2(TX_DEPTH)+1  TX FIFO occupancy
rx_level  out  $clog2(RX_DEPTH)+1  RX FIFO occupancy
rx_ovf  out  1  sticky: a frame was received while the RX FIFO was full
frame_err  out  1  sticky: a stop bit sampled as 0
tx_busy  out  1  FIFO non-empty, or TX state machine not in T_IDLE
u_tdata  out  1  to UART tdata_i; one-cycle load strobe
u_wdata  out  16  to UART data_i
u_rdata  in  16  from UART data_o; bit13 = TBE, bit9 = stop bit, bits7:0 = RX byte
u_txint  in  1  UART TX start pulse
u_rxint  in  1  UART RX complete pulse
u_rbfmirror  out  1  to UART rbfmirror
u_uartbrk  out  1  to UART uartbrk

Behaviour:
- All state is clocked on the rising edge of clk. reset is synchronous and active-high. Reset mid-frame aborts the TX state machine and empties both FIFOs.
- Reset values: wr_ready=1, rd_valid=0, u_tdata=0, u_wdata=16'h0000, u_rbfmirror=0, u_uartbrk=0, tx_level=0, rx_level=0, rx_ovf=0, frame_err=0, tx_busy=0.
- TX FIFO:
  - Push when wr_valid && wr_ready.
  - A write offered while full is ignored; no flag is raised.
  - Pointers wrap modulo the depth.
  - Push and pop in the same cycle are legal; the level is unchanged.
- u_wdata format: {7'b0, 1'b1, byte}, i.e. 16'h01xx. This encodes 8 data bits plus 1 stop bit in the UART shift register.
- TX state machine:
  - T_IDLE: if TX FIFO non-empty && u_rdata[13] && !brk_req, then in the same edge register u_wdata = head, pulse u_tdata for 1 cycle, pop FIFO, go to T_START.
  - T_START: wait for u_txint, then go to T_RUN. Watchdog: if u_txint is absent after 8 cycles, go to T_RUN anyway.
  - T_RUN: wait for u_rdata[13]==1, then go to T_IDLE.
  - Exactly one u_tdata strobe per frame. No strobe is ever issued while TBE=0.
  - Latency from the first push into an empty FIFO (UART idle) to u_tdata is 2 cycles.
- Break:
  - u_uartbrk = registered brk_req (1-cycle latency).
  - A frame already in flight completes (the line is forced low by the UART).
  - No new launch occurs while brk_req=1.
- RX capture:
  - On a cycle with u_rxint=1, sample u_rdata[7:0] and u_rdata[9].
  - If RX FIFO full (level before any same-cycle pop): drop the byte and set rx_ovf.
  - Otherwise push the byte. If u_rdata[9]==0, set frame_err; the byte is still pushed.
- RX pop: when rd_valid && rd_ready. rd_data is combinationally the head entry.
- u_rbfmirror = registered (rx_level == RX_DEPTH).
- Sticky flags: clr_status clears rx_ovf and frame_err. A set event in the same cycle as clr_status wins (flag = 1).
- Level outputs are registered and exact at all times, including the full and empty boundaries.

Optional Feature:
UART_FIFO_CTRL_RTS_EN
- Defined:
  - Adds output rts_n (1 bit, reset 0).
  - rts_n is registered; it goes to 1 when RX_DEPTH - rx_level <= RTS_MARGIN, and returns to 0 when RX_DEPTH - rx_level >= 2*RTS_MARGIN (hysteresis).
  - Adds input cts_n; T_IDLE will not launch while cts_n=1.
- Undefined: neither port exists, and launches depend only on TBE and brk_req.

Test Plan:
- Reset, then write 0x5A with the UART idle -> u_tdata on cycle 2 with u_wdata=16'h015A; a serial monitor decodes 0x5A at 115200 baud; tx_busy clears after the frame.
- Burst-write 16 bytes 0x00..0x0F (TX_DEPTH=16) then a 17th -> wr_ready=0 after the 16th and the 17th is dropped; exactly 16 strobes in order, never with TBE=0; tx_level counts 16 down to 0.
- Drive 20 serial frames into rxd with rd_ready=0 (RX_DEPTH=16) -> rx_level saturates at 16; u_rbfmirror=1; rx_ovf=1; popping yields the first 16 bytes in order.
- Frame with stop bit 0 carrying 0xA3 -> 0xA3 is pushed and frame_err=1. clr_status in the same cycle as a new error leaves frame_err=1; a later clr_status clears it.
- Assert brk_req mid-frame -> the frame completes, u_uartbrk=1, and queued bytes are held. Release -> sending resumes from the next byte.
- Assert reset in T_RUN with 5 bytes queued -> all outputs take their reset values and tx_level=0; no u_tdata until a new write.
